// File: rtl/sccb_config_sequencer_if.sv
// Engine-side bus between the configuration sequencer and the byte-level SCCB write engine.
// The sequencer is the master; the write engine is the slave.
interface sccb_config_sequencer_if;
  logic       eng_start;
  logic [7:0] eng_reg_addr;
  logic [7:0] eng_reg_data;
  logic       eng_busy;
  logic       eng_done;
  logic       eng_nack;

  modport master (
    output eng_start, eng_reg_addr, eng_reg_data,
    input  eng_busy, eng_done, eng_nack
  );

  modport slave (
    input  eng_start, eng_reg_addr, eng_reg_data,
    output eng_busy, eng_done, eng_nack
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// OV7670 configuration sequencer: walks the config ROM after power-up, honours delay/end
// markers and COM7 soft reset, then serves runtime user writes on the same SCCB engine.
module sccb_config_sequencer #(
  parameter int ROM_LEN           = 72,
  parameter int POWERUP_CYCLES    = 25000,
  parameter int RESET_WAIT_CYCLES = 25000,
  parameter int MAX_RETRY         = 3
) (
  input  logic                    xclk,
  input  logic                    reset,
  input  logic                    i_start,
  output logic [7:0]              o_rom_addr,
  input  logic [15:0]             i_rom_data,
  input  logic                    i_user_req,
  input  logic [7:0]              i_user_reg_addr,
  input  logic [7:0]              i_user_reg_data,
  output logic                    o_user_ack,
  sccb_config_sequencer_if.master eng,
  output logic                    o_config_done,
  output logic                    o_busy,
  output logic                    o_error,
  output logic [7:0]              o_write_count
);

  localparam int MAX_CYC = (POWERUP_CYCLES > RESET_WAIT_CYCLES) ? POWERUP_CYCLES : RESET_WAIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // PWRUP spans its entry cycle plus POWERUP_CYCLES, so it ends on a count of POWERUP_CYCLES.
  localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0]   DLY_LAST  = CNT_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [7:0]         ROM_END   = 8'(ROM_LEN);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PWRUP   = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_ISSUE   = 4'd4,
    S_WAIT    = 4'd5,
    S_DELAY   = 4'd6,
    S_RUN     = 4'd7,
    S_U_ISSUE = 4'd8,
    S_U_WAIT  = 4'd9
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic [7:0]         r_rom_addr,    w_rom_addr_nxt;
  logic [CNT_W-1:0]   r_cnt,         w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry,       w_retry_nxt;
  logic               r_eng_start,   w_eng_start_nxt;
  logic [7:0]         r_eng_addr,    w_eng_addr_nxt;
  logic [7:0]         r_eng_data,    w_eng_data_nxt;
  logic               r_user_ack,    w_user_ack_nxt;
  logic               r_config_done, w_config_done_nxt;
  logic               r_busy,        w_busy_nxt;
  logic               r_error,       w_error_nxt;
  logic [7:0]         r_write_count, w_write_count_nxt;
  logic               w_com7_reset;
  logic               w_retry_left;

  assign w_com7_reset = (r_eng_addr == 8'h12) && r_eng_data[7];
  assign w_retry_left = (r_retry < RETRY_MAX);

  // State and registered-output update.
  always_ff @(posedge xclk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rom_addr    <= 8'd0;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_eng_start   <= 1'b0;
      r_eng_addr    <= 8'd0;
      r_eng_data    <= 8'd0;
      r_user_ack    <= 1'b0;
      r_config_done <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
      r_write_count <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_rom_addr    <= w_rom_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_retry       <= w_retry_nxt;
      r_eng_start   <= w_eng_start_nxt;
      r_eng_addr    <= w_eng_addr_nxt;
      r_eng_data    <= w_eng_data_nxt;
      r_user_ack    <= w_user_ack_nxt;
      r_config_done <= w_config_done_nxt;
      r_busy        <= w_busy_nxt;
      r_error       <= w_error_nxt;
      r_write_count <= w_write_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_rom_addr_nxt    = r_rom_addr;
    w_cnt_nxt         = r_cnt;
    w_retry_nxt       = r_retry;
    w_eng_start_nxt   = 1'b0;
    w_eng_addr_nxt    = r_eng_addr;
    w_eng_data_nxt    = r_eng_data;
    w_user_ack_nxt    = 1'b0;
    w_config_done_nxt = r_config_done;
    w_error_nxt       = r_error;
    w_write_count_nxt = r_write_count;

    case (r_state)
      S_IDLE, S_RUN: begin
        if (i_start) begin
          w_state_nxt       = S_PWRUP;
          w_rom_addr_nxt    = 8'd0;
          w_cnt_nxt         = '0;
          w_retry_nxt       = '0;
          w_config_done_nxt = 1'b0;
          w_error_nxt       = 1'b0;
          w_write_count_nxt = 8'd0;
        end else if ((r_state == S_RUN) && i_user_req) begin
          w_state_nxt    = S_U_ISSUE;
          w_eng_addr_nxt = i_user_reg_addr;
          w_eng_data_nxt = i_user_reg_data;
          w_retry_nxt    = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_PWRUP: begin
        if (r_cnt == PWR_LAST) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if ((r_rom_addr == ROM_END) || (i_rom_data == 16'hFFFF)) begin
          w_state_nxt       = S_RUN;
          w_config_done_nxt = 1'b1;
        end else if (i_rom_data == 16'hFFF0) begin
          w_state_nxt = S_DELAY;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt    = S_ISSUE;
          w_eng_addr_nxt = i_rom_data[15:8];
          w_eng_data_nxt = i_rom_data[7:0];
          w_retry_nxt    = '0;
        end
      end
      S_ISSUE, S_U_ISSUE: begin
        if (!eng.eng_busy) begin
          w_eng_start_nxt = 1'b1;
          w_state_nxt     = (r_state == S_ISSUE) ? S_WAIT : S_U_WAIT;
        end else begin
          w_eng_start_nxt = 1'b0;
        end
      end
      S_WAIT, S_U_WAIT: begin
        if (!eng.eng_done) begin
          w_state_nxt = r_state;
        end else if (eng.eng_nack && w_retry_left) begin
          w_retry_nxt = r_retry + {{(RETRY_W-1){1'b0}}, 1'b1};
          w_state_nxt = (r_state == S_WAIT) ? S_ISSUE : S_U_ISSUE;
        end else begin
          // Entry finished: acknowledged, or NACKed with every retry used up.
          w_retry_nxt = '0;
          w_error_nxt = r_error | eng.eng_nack;
          if (r_state == S_U_WAIT) begin
            w_user_ack_nxt = 1'b1;
            w_state_nxt    = S_RUN;
          end else if (!eng.eng_nack && w_com7_reset) begin
            w_write_count_nxt = (r_write_count == 8'hFF) ? 8'hFF : r_write_count + 8'd1;
            w_state_nxt       = S_DELAY;
            w_cnt_nxt         = '0;
          end else begin
            w_write_count_nxt = (eng.eng_nack || (r_write_count == 8'hFF)) ?
                                r_write_count : r_write_count + 8'd1;
            w_rom_addr_nxt    = r_rom_addr + 8'd1;
            w_state_nxt       = S_FETCH;
          end
        end
      end
      S_DELAY: begin
        if (r_cnt == DLY_LAST) begin
          w_state_nxt    = S_FETCH;
          w_rom_addr_nxt = r_rom_addr + 8'd1;
          w_cnt_nxt      = '0;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_RUN);
  end

  assign o_rom_addr       = r_rom_addr;
  assign o_user_ack       = r_user_ack;
  assign o_config_done    = r_config_done;
  assign o_busy           = r_busy;
  assign o_error          = r_error;
  assign o_write_count    = r_write_count;
  assign eng.eng_start    = r_eng_start;
  assign eng.eng_reg_addr = r_eng_addr;
  assign eng.eng_reg_data = r_eng_data;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Scoreboard bench for sccb_config_sequencer: a ROM/engine model drives the DUT, a reference
// walk of the ROM predicts every engine write (address, data, spacing) and the final status.
module tb_sccb_config_sequencer;
  localparam int ROM_LEN = 8;
  localparam int P       = 10;
  localparam int W       = 20;
  localparam int MR      = 3;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic        xclk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_user_req = 1'b0;
  logic [7:0]  i_user_reg_addr = 8'd0;
  logic [7:0]  i_user_reg_data = 8'd0;
  logic [15:0] i_rom_data;
  logic [7:0]  o_rom_addr;
  logic        o_user_ack, o_config_done, o_busy, o_error;
  logic [7:0]  o_write_count;

  sccb_config_sequencer_if eng_if ();

  sccb_config_sequencer #(
    .ROM_LEN(ROM_LEN), .POWERUP_CYCLES(P), .RESET_WAIT_CYCLES(W), .MAX_RETRY(MR)
  ) dut (
    .xclk(xclk), .reset(reset), .i_start(i_start), .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data), .i_user_req(i_user_req), .i_user_reg_addr(i_user_reg_addr),
    .i_user_reg_data(i_user_reg_data), .o_user_ack(o_user_ack), .eng(eng_if),
    .o_config_done(o_config_done), .o_busy(o_busy), .o_error(o_error),
    .o_write_count(o_write_count)
  );

  exp_t        exp_q[$];
  bit          nack_q[$];
  logic [15:0] rom [ROM_LEN];
  int          nk [ROM_LEN];
  int          checks = 0, errors = 0;
  int          cyc = 0, t_ref = 0;
  int          start_cnt = 0, ack_cnt = 0;
  int          exp_wc;
  bit          exp_err;

  initial forever #5 xclk = ~xclk;

  always @(posedge xclk) cyc <= cyc + 1;

  // Registered ROM: data follows the address by one clock.
  always @(posedge xclk) i_rom_data <= (o_rom_addr < 8'd8) ? rom[o_rom_addr[2:0]] : 16'hFFFF;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: busy after start, done (with queued NACK decision) 5 cycles later.
  initial begin : engine
    bit nb;
    eng_if.eng_busy = 1'b0;
    eng_if.eng_done = 1'b0;
    eng_if.eng_nack = 1'b0;
    forever begin
      @(negedge xclk);
      if (eng_if.eng_start) begin
        nb = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        eng_if.eng_busy = 1'b1;
        repeat (4) @(negedge xclk);
        eng_if.eng_done = 1'b1;
        eng_if.eng_nack = nb;
        t_ref = cyc + 1;
        @(negedge xclk);
        eng_if.eng_done = 1'b0;
        eng_if.eng_nack = 1'b0;
        eng_if.eng_busy = 1'b0;
      end
    end
  end

  // Monitor: every engine write is popped from the scoreboard and compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge xclk);
      if (eng_if.eng_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_eng_start: got 0x%0h/0x%0h expected none",
                   eng_if.eng_reg_addr, eng_if.eng_reg_data);
        end else begin
          e = exp_q.pop_front();
          chk("eng_reg_addr", int'(eng_if.eng_reg_addr), int'(e.addr));
          chk("eng_reg_data", int'(eng_if.eng_reg_data), int'(e.data));
          if (e.gap >= 0) chk("eng_start_spacing", cyc - t_ref, e.gap);
        end
      end
      if (o_user_ack) begin
        ack_cnt++;
        chk("user_ack_after_config", int'(o_config_done), 1);
      end
    end
  end

  // Reference walk of the ROM: spacing counted in clocks from the event that enabled the write.
  task automatic build_model(input bit user, input logic [7:0] ua, input logic [7:0] ud,
                             input int unk);
    int gap;
    bit nb;
    exp_q.delete();
    nack_q.delete();
    gap     = P + 4;
    exp_wc  = 0;
    exp_err = 1'b0;
    for (int i = 0; i < ROM_LEN; i++) begin
      if (rom[i] == 16'hFFFF) break;
      if (rom[i] == 16'hFFF0) begin
        gap += W + 2;
        continue;
      end
      for (int a = 0; a <= MR; a++) begin
        nb = (a < nk[i]);
        exp_q.push_back('{rom[i][15:8], rom[i][7:0], (a == 0) ? gap : 1});
        nack_q.push_back(nb);
        gap = 3;
        if (!nb) begin
          exp_wc++;
          if (rom[i][15:8] == 8'h12 && rom[i][7]) gap = 3 + W;
          break;
        end
        if (a == MR) exp_err = 1'b1;
      end
    end
    if (user) begin
      for (int a = 0; a <= MR; a++) begin
        nb = (a < unk);
        exp_q.push_back('{ua, ud, (a == 0) ? gap + 1 : 1});
        nack_q.push_back(nb);
        if (!nb) break;
        if (a == MR) exp_err = 1'b1;
      end
    end
    if (exp_wc > 255) exp_wc = 255;
  endtask

  task automatic load_rom(input logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7);
    rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3;
    rom[4] = r4; rom[5] = r5; rom[6] = r6; rom[7] = r7;
    for (int i = 0; i < ROM_LEN; i++) nk[i] = 0;
  endtask

  task automatic run_cfg(input string tag, input bit user, input int user_off,
                         input logic [7:0] ua, input logic [7:0] ud, input int unk);
    int n;
    int acks0;
    acks0 = ack_cnt;
    build_model(user, ua, ud, unk);
    @(negedge xclk);
    i_start = 1'b1;
    t_ref   = cyc + 1;
    if (user && user_off == 0) begin
      i_user_req = 1'b1; i_user_reg_addr = ua; i_user_reg_data = ud;
    end
    @(negedge xclk);
    i_start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(o_busy), 1);
    chk({tag, "_config_done_cleared"}, int'(o_config_done), 0);
    if (user && user_off != 0) begin
      i_user_req = 1'b1; i_user_reg_addr = ua; i_user_reg_data = ud;
    end
    n = 0;
    while (!o_config_done && n < 5000) begin @(negedge xclk); n++; end
    chk({tag, "_config_done"}, int'(o_config_done), 1);
    if (user) begin
      n = 0;
      while (!o_user_ack && n < 1000) begin @(negedge xclk); n++; end
      chk({tag, "_user_ack_seen"}, int'(o_user_ack), 1);
      i_user_req = 1'b0;
    end
    n = 0;
    while ((exp_q.size() != 0 || eng_if.eng_busy) && n < 1000) begin @(negedge xclk); n++; end
    repeat (5) @(negedge xclk);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    chk({tag, "_write_count"}, int'(o_write_count), exp_wc);
    chk({tag, "_error"}, int'(o_error), int'(exp_err));
    chk({tag, "_busy_idle"}, int'(o_busy), 0);
    chk({tag, "_user_acks"}, ack_cnt - acks0, user ? 1 : 0);
  endtask

  initial begin : stimulus
    int n, s0;
    load_rom(16'h1280, 16'h1204, 16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge xclk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_config_done", int'(o_config_done), 0);
    chk("rst_error", int'(o_error), 0);
    chk("rst_write_count", int'(o_write_count), 0);
    chk("rst_rom_addr", int'(o_rom_addr), 0);
    chk("rst_eng_start", int'(eng_if.eng_start), 0);
    chk("rst_eng_reg_addr", int'(eng_if.eng_reg_addr), 0);
    chk("rst_eng_reg_data", int'(eng_if.eng_reg_data), 0);
    chk("rst_user_ack", int'(o_user_ack), 0);
    reset = 1'b0;

    run_cfg("base", 1'b0, 0, 8'h00, 8'h00, 0);
    nk[1] = 5;
    run_cfg("nack_all", 1'b0, 0, 8'h00, 8'h00, 0);
    nk[1] = 1;
    run_cfg("nack_once", 1'b0, 0, 8'h00, 8'h00, 0);
    nk[1] = 0;
    run_cfg("user_pending", 1'b1, 1, 8'h1E, 8'h30, 0);
    run_cfg("restart_wins", 1'b1, 0, 8'h0F, 8'h55, 0);
    run_cfg("user_nack_out", 1'b1, 0, 8'h3A, 8'h04, 5);

    load_rom(16'h1300, 16'h1301, 16'h1302, 16'h1303, 16'h1304, 16'h1305, 16'h1306, 16'h1307);
    run_cfg("rom_len_end", 1'b0, 0, 8'h00, 8'h00, 0);

    // Reset while the second write is outstanding.
    load_rom(16'h1280, 16'h1204, 16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    build_model(1'b0, 8'h00, 8'h00, 0);
    s0 = start_cnt;
    @(negedge xclk);
    i_start = 1'b1;
    t_ref   = cyc + 1;
    @(negedge xclk);
    i_start = 1'b0;
    n = 0;
    while (start_cnt < s0 + 2 && n < 2000) begin @(negedge xclk); n++; end
    chk("mid_wait_starts", start_cnt - s0, 2);
    @(negedge xclk);
    chk("mid_wait_write_count", int'(o_write_count), 1);
    reset = 1'b1;
    @(negedge xclk);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_config_done", int'(o_config_done), 0);
    chk("mid_rst_write_count", int'(o_write_count), 0);
    chk("mid_rst_eng_start", int'(eng_if.eng_start), 0);
    reset = 1'b0;
    exp_q.delete();
    nack_q.delete();
    s0 = start_cnt;
    repeat (60) @(negedge xclk);
    chk("post_rst_no_start", start_cnt - s0, 0);
    chk("post_rst_busy", int'(o_busy), 0);

    for (int it = 0; it < 6; it++) begin
      int r;
      for (int i = 0; i < ROM_LEN; i++) begin
        r = $urandom_range(0, 99);
        if (r < 8)       rom[i] = 16'hFFF0;
        else if (r < 12) rom[i] = 16'hFFFF;
        else if (r < 25) rom[i] = {8'h12, 8'($urandom_range(0, 255))};
        else             rom[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        r = $urandom_range(0, 99);
        nk[i] = (r < 60) ? 0 : (r < 80) ? 1 : $urandom_range(2, 5);
      end
      run_cfg("random", 1'($urandom_range(0, 1)), $urandom_range(0, 1),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sccb_config_sequencer.md
# sccb_config_sequencer

Sequences OV7670 register configuration over the SCCB link. It walks the camera configuration ROM after a power-up delay and honours in-table delay and end markers. It hands each register write to a byte-level SCCB write engine through a start/busy/done handshake. Once configuration is finished, it arbitrates runtime register writes from a user requester, such as exposure or mirror controls, onto the same engine.

## Interface
- ROM_LEN, 72, maximum number of ROM entries walked; the sequence ends at index ROM_LEN even without an end marker
- POWERUP_CYCLES, 25000, xclk cycles waited after start before the first write (1 ms at 25 MHz)
- RESET_WAIT_CYCLES, 25000, xclk cycles waited after a soft-reset write or a delay marker
- MAX_RETRY, 3, extra attempts after a NACK before an entry is skipped
- xclk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins (or restarts) the configuration sequence
- rom_addr  out  8  ROM entry index
- rom_data  in  16  ROM entry {reg_addr[15:8], reg_data[7:0]}; valid one cycle after rom_addr changes
- user_req  in  1  level; runtime write request, held until user_ack
- user_reg_addr  in  8  runtime register address, stable while user_req=1
- user_reg_data  in  8  runtime register data, stable while user_req=1
- user_ack  out  1  one-cycle pulse when the runtime write completes (ACK or final NACK)
- eng_start  out  1  one-cycle pulse requesting one 3-phase SCCB write to ID 0x42
- eng_reg_addr  out  8  register address for the engine
- eng_reg_data  out  8  register data for the engine
- eng_busy  in  1  engine transaction in progress
- eng_done  in  1  one-cycle pulse at transaction end
- eng_nack  in  1  qualified by eng_done; 1 means the slave did not acknowledge
- config_done  out  1  high once the ROM sequence has finished; low after reset or start
- busy  out  1  high in every state except IDLE and RUN
- error  out  1  sticky; set when an entry or user write exhausts its retries; cleared by start or reset
- write_count  out  8  number of ROM writes acknowledged; saturates at 255

## Operation
- States:
  - IDLE
  - PWRUP
  - FETCH
  - DECODE
  - ISSUE
  - WAIT
  - DELAY
  - RUN
  - U_ISSUE
  - U_WAIT
- IDLE, start=1: go to PWRUP; clear counters, error, config_done and write_count; set rom_addr=0.
- PWRUP: count POWERUP_CYCLES, then go to FETCH.
- FETCH: one cycle, lets the ROM output settle. Then go to DECODE, which samples rom_data.
- DECODE:
  - 16'hFFFF (end marker) or rom_addr==ROM_LEN: go to RUN and set config_done.
  - 16'hFFF0 (delay marker): go to DELAY without a write.
  - Otherwise: latch eng_reg_addr/eng_reg_data and go to ISSUE.
- ISSUE: pulse eng_start in the first cycle with eng_busy=0, then go to WAIT. eng_reg_addr/eng_reg_data are held from the pulse until eng_done.
- WAIT, eng_done=1:
  - ACK: increment write_count.
    - If reg 0x12 with data bit7=1 (COM7 soft reset): go to DELAY.
    - Otherwise: rom_addr+1, go to FETCH.
  - NACK with retries left: increment the retry counter, go back to ISSUE.
  - NACK with retries exhausted: set error, reset the retry counter, rom_addr+1, go to FETCH.
- DELAY: count RESET_WAIT_CYCLES, then rom_addr+1 and go to FETCH.
- RUN:
  - start=1 takes priority over user_req: restart exactly as from IDLE.
  - Otherwise, user_req=1: latch the user address/data and go to U_ISSUE.
- U_ISSUE and U_WAIT use the same handshake and retry rules as ISSUE and WAIT. On completion, pulse user_ack and return to RUN. write_count is not changed by user writes.
- Arbitration:
  - ROM sequence has absolute priority.
  - user_req asserted during configuration stays pending and unacknowledged; it is served in the first RUN cycle.
- start in any busy state is ignored.
- The retry counter is $clog2(MAX_RETRY+1) bits and resets on each new entry.
- Delay counters are sized from max(POWERUP_CYCLES, RESET_WAIT_CYCLES).

## Timing
- Reset values:
  - state=IDLE, rom_addr=0
  - eng_start=0, eng_reg_addr=0, eng_reg_data=0
  - user_ack=0, config_done=0, busy=0, error=0, write_count=0
- Reset mid-transaction: return to IDLE next cycle. eng_start must not pulse during reset; any later eng_done is ignored.
- Latency:
  - start to first eng_start = POWERUP_CYCLES + 4 cycles with eng_busy=0 (PWRUP entry, FETCH, DECODE, ISSUE).
  - ACKed eng_done to next eng_start = 3 cycles (FETCH, DECODE, ISSUE).
  - user_req in RUN to eng_start = 2 cycles. eng_done to user_ack = 1 cycle.
- eng_done outside WAIT/U_WAIT is ignored.
- All outputs are registered.

## Test plan
- Bench parameters: POWERUP_CYCLES=10, RESET_WAIT_CYCLES=20, ROM {0x1280, 0x1204, 0xFFF0, 0x1100, 0xFFFF}, engine model raises eng_done 5 cycles after eng_start with ACK.
  - start -> first eng_start 14 cycles later with 0x12/0x80.
  - 20-cycle gap (DELAY) after 0x1280.
  - Writes 0x1204 then a further 20-cycle DELAY for 0xFFF0, then 0x1100.
  - config_done=1, write_count=3, error=0.
- NACK always on entry 0x1204, MAX_RETRY=3 -> 4 eng_start pulses carry 0x12/0x04, error=1, sequence continues, write_count=2.
- NACK once, then ACK -> exactly 2 pulses carry 0x12/0x04, error=0.
- user_req=1 (0x1E/0x30) asserted right after start -> no user_ack before config_done. First RUN transaction carries 0x1E/0x30, then one user_ack pulse.
- Reset asserted while in WAIT -> next cycle busy=0, config_done=0, write_count=0; no eng_start until the next start.
- start asserted in RUN together with user_req -> restart wins: PWRUP entered, config_done=0, user write deferred until config_done returns.
